// File: rtl/uart_pkg.sv
// Shared UART definitions: default frame constants and the receiver state encoding.
// The PARITY state is only present when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;
    localparam int UART_STOP_BITS  = 1;
    localparam int UART_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line.
// Resets to 1 so an idle line never looks like a start bit after reset.
module uart_sync2 (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/parity/stop reception with a valid/ready output.
// Define UART_RX_PARITY_EN to expect a parity bit between the data and stop bits.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int STOP_BITS  = UART_STOP_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int PARITY_ODD = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  baud_tick,
    input  logic                  rx_serial,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  rx_busy,
    output logic                  frame_err,
    output logic                  parity_err,
    output logic                  overrun_err
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_WIDTH + 1);

    localparam logic [TW-1:0] TCNT_MID       = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TCNT_END       = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BCNT_DATA_LAST = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0] BCNT_STOP_LAST = BW'(STOP_BITS - 1);

    // Reject configurations the counters and sampling points cannot represent.
    if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
        $error("uart_rx: OVERSAMPLE must be even and at least 4");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_rx: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
        $error("uart_rx: PARITY_ODD must be 0 or 1");
    end

    logic s_rx;

    rx_state_e             state_q,       state_d;
    logic [TW-1:0]         tcnt_q,        tcnt_d;
    logic [BW-1:0]         bcnt_q,        bcnt_d;
    logic [DATA_WIDTH-1:0] shift_q,       shift_d;
    logic                  frame_fault_q, frame_fault_d;
    logic [DATA_WIDTH-1:0] rx_data_q,     rx_data_d;
    logic                  rx_valid_q,    rx_valid_d;
    logic                  frame_err_q,   frame_err_d;
    logic                  overrun_err_q, overrun_err_d;
    logic                  stop_fault;

`ifdef UART_RX_PARITY_EN
    localparam logic PAR_SENSE = (PARITY_ODD != 0);

    logic parity_bad_q, parity_bad_d;
    logic parity_err_q, parity_err_d;
`endif

    uart_sync2 u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (rx_serial),
        .q       (s_rx)
    );

    always_comb begin
        state_d       = state_q;
        tcnt_d        = tcnt_q;
        bcnt_d        = bcnt_q;
        shift_d       = shift_q;
        frame_fault_d = frame_fault_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q & ~rx_ready;
        frame_err_d   = 1'b0;
        overrun_err_d = 1'b0;
        stop_fault    = frame_fault_q | ~s_rx;
`ifdef UART_RX_PARITY_EN
        parity_bad_d  = parity_bad_q;
        parity_err_d  = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (baud_tick && !s_rx) begin
                    tcnt_d  = '0;
                    state_d = START;
                end
            end

            // Re-check the line half a bit in so short glitches are rejected.
            START: begin
                if (baud_tick) begin
                    if (tcnt_q == TCNT_MID) begin
                        if (s_rx) begin
                            state_d = IDLE;
                        end else begin
                            tcnt_d  = '0;
                            bcnt_d  = '0;
                            state_d = DATA;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end

            DATA: begin
                if (baud_tick) begin
                    if (tcnt_q == TCNT_END) begin
                        tcnt_d  = '0;
                        shift_d = {s_rx, shift_q[DATA_WIDTH-1:1]};
                        bcnt_d  = bcnt_q + 1'b1;
                        if (bcnt_q == BCNT_DATA_LAST) begin
                            bcnt_d        = '0;
                            frame_fault_d = 1'b0;
`ifdef UART_RX_PARITY_EN
                            parity_bad_d  = 1'b0;
                            state_d       = PARITY;
`else
                            state_d       = STOP;
`endif
                        end
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (baud_tick) begin
                    if (tcnt_q == TCNT_END) begin
                        tcnt_d       = '0;
                        parity_bad_d = s_rx ^ (^shift_q) ^ PAR_SENSE;
                        state_d      = STOP;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
`endif

            // Leave for IDLE on the last stop sample so a start edge in the
            // second half of the stop bit is still caught.
            STOP: begin
                if (baud_tick) begin
                    if (tcnt_q == TCNT_END) begin
                        tcnt_d        = '0;
                        bcnt_d        = bcnt_q + 1'b1;
                        frame_fault_d = stop_fault;
                        if (bcnt_q == BCNT_STOP_LAST) begin
                            bcnt_d  = '0;
                            state_d = IDLE;
                            if (stop_fault) begin
                                frame_err_d = 1'b1;
                            end else if (rx_valid_q && !rx_ready) begin
                                overrun_err_d = 1'b1;
                            end else begin
                                rx_data_d    = shift_q;
                                rx_valid_d   = 1'b1;
`ifdef UART_RX_PARITY_EN
                                parity_err_d = parity_bad_q;
`endif
                            end
                        end
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            tcnt_q        <= '0;
            bcnt_q        <= '0;
            shift_q       <= '0;
            frame_fault_q <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            tcnt_q        <= tcnt_d;
            bcnt_q        <= bcnt_d;
            shift_q       <= shift_d;
            frame_fault_q <= frame_fault_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            frame_err_q   <= frame_err_d;
            overrun_err_q <= overrun_err_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            parity_bad_q <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            parity_bad_q <= parity_bad_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign rx_busy     = (state_q != IDLE);
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_err_q;

endmodule
